// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word at a time from instruction
// memory and hands each instruction with its PC to the decoder over valid/ready.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic [63:0] fetch_cnt
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic [63:0] r_fetch_pc;
    logic        r_drop;
    logic [31:0] r_inst;
    logic [63:0] r_inst_pc;
    logic        r_inst_valid;
    logic        r_req_valid;
    logic        r_halted;
    logic [63:0] r_fetch_cnt;

    logic [1:0]  w_state_nx;
    logic [63:0] w_pc_nx;
    logic [63:0] w_fetch_pc_nx;
    logic        w_drop_nx;
    logic [31:0] w_inst_nx;
    logic [63:0] w_inst_pc_nx;
    logic [63:0] w_fetch_cnt_nx;
    logic        w_req_fire;
    logic        w_deliver;
    logic        w_is_ebreak;

    assign w_req_fire  = r_req_valid & imem_req_ready;
    assign w_deliver   = r_inst_valid & inst_ready;
    assign w_is_ebreak = (r_inst == EBREAK_INST);

    // Next-state, PC and drop-flag computation; a redirect outranks the sequential PC.
    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_fetch_pc_nx  = r_fetch_pc;
        w_drop_nx      = r_drop;
        w_inst_nx      = r_inst;
        w_inst_pc_nx   = r_inst_pc;
        w_fetch_cnt_nx = r_fetch_cnt;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_fetch_pc_nx = r_pc;
                    w_state_nx    = S_WAIT;
                    w_drop_nx     = redirect_valid;
                end else begin
                    w_state_nx = S_REQ;
                end
                if (redirect_valid) begin
                    w_pc_nx = redirect_pc;
                end else begin
                    w_pc_nx = r_pc;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_drop || redirect_valid) begin
                        w_drop_nx  = 1'b0;
                        w_state_nx = S_REQ;
                    end else begin
                        w_inst_nx    = imem_rsp_data;
                        w_inst_pc_nx = r_fetch_pc;
                        w_state_nx   = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_drop_nx = 1'b1;
                end else begin
                    w_drop_nx = r_drop;
                end
                if (redirect_valid) begin
                    w_pc_nx = redirect_pc;
                end else begin
                    w_pc_nx = r_pc;
                end
            end
            S_HOLD: begin
                // A handshake coinciding with a redirect still counts and may still halt.
                if (w_deliver) begin
                    w_fetch_cnt_nx = r_fetch_cnt + 64'd1;
                    if (w_is_ebreak) begin
                        w_state_nx = S_HALT;
                    end else if (redirect_valid) begin
                        w_state_nx = S_REQ;
                        w_pc_nx    = redirect_pc;
                    end else begin
                        w_state_nx = S_REQ;
                        w_pc_nx    = r_inst_pc + 64'd4;
                    end
                end else if (redirect_valid) begin
                    w_state_nx = S_REQ;
                    w_pc_nx    = redirect_pc;
                end else begin
                    w_state_nx = S_HOLD;
                end
            end
            S_HALT: begin
                w_state_nx = S_HALT;
            end
            default: begin
                w_state_nx = S_REQ;
                w_drop_nx  = 1'b0;
            end
        endcase
    end

    // State registers; handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= 64'd0;
            r_drop       <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 64'd0;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b0;
            r_halted     <= 1'b0;
            r_fetch_cnt  <= 64'd0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_fetch_pc   <= w_fetch_pc_nx;
            r_drop       <= w_drop_nx;
            r_inst       <= w_inst_nx;
            r_inst_pc    <= w_inst_pc_nx;
            r_inst_valid <= (w_state_nx == S_HOLD);
            r_req_valid  <= (w_state_nx == S_REQ);
            r_halted     <= (w_state_nx == S_HALT);
            r_fetch_cnt  <= w_fetch_cnt_nx;
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign halted         = r_halted;
    assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: doc/ysyx_22050612_ifu.md
Name: ysyx_22050612_ifu

Overview:
- Instruction fetch unit: the producer side of the 32-bit instruction interface consumed by the decoder.
- Holds the PC and issues word reads to instruction memory over a valid/ready request and response handshake.
- Delivers each fetched instruction and its PC to the decoder over a valid/ready handshake.
- Accepts redirects (jal/jalr/branch targets) from execute and stops fetching after delivering ebreak (32'h00100073).

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded at reset
EBREAK_INST, 32'h0010_0073, encoding that halts fetch once delivered

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  64  fetch address (= pc)
imem_rsp_valid  input  1  read data valid (memory never stalls response)
imem_rsp_data  input  32  fetched instruction word
inst_valid  output  1  instruction available to decoder
inst_ready  input  1  decoder consumes instruction
inst  output  32  instruction word
inst_pc  output  64  PC of inst
redirect_valid  input  1  one-cycle pulse: change fetch stream
redirect_pc  input  64  new PC
halted  output  1  ebreak delivered, fetch stopped
fetch_cnt  output  64  number of instructions handed to decoder

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=S_REQ, drop=0, inst=0, inst_pc=0, inst_valid=0, imem_req_valid=0, halted=0, fetch_cnt=0.
- imem_req_valid is 1 only in S_REQ; imem_addr=pc at all times.
- inst_valid is 1 only in S_HOLD; inst and inst_pc are registered and stable while inst_valid=1.
- States:
  - S_REQ: on imem_req_valid&&imem_req_ready, latch fetch_pc=pc and go to S_WAIT. Otherwise stay.
  - S_WAIT: on imem_rsp_valid with drop=0, register inst=imem_rsp_data and inst_pc=fetch_pc, then go to S_HOLD. With drop=1, discard the data, clear drop, go to S_REQ.
  - S_HOLD: on inst_ready, fetch_cnt+=1. pc=inst_pc+4 (wraps mod 2^64). Next state is S_HALT if inst==EBREAK_INST, else S_REQ.
  - S_HALT: halted=1. No requests. Redirects ignored. Exit only via reset.
- Minimum latency is 3 cycles per instruction: request accepted (cycle 0), response registered (cycle 1), handshake at the end of cycle 2. No overlap between instructions.
- Redirect (redirect_valid=1) has priority over normal pc update in every state except S_HALT. pc<=redirect_pc on the next edge.
  - S_REQ, request not accepted this cycle: stay in S_REQ. The next request uses redirect_pc.
  - S_REQ, request accepted the same cycle: go to S_WAIT with drop=1.
  - S_WAIT: drop<=1. If the response arrives the same cycle, discard it and go to S_REQ with drop=0.
  - S_HOLD: go to S_REQ and clear inst_valid. If inst_ready is also 1, the handshake still counts (fetch_cnt+=1) and the ebreak check still applies (S_HALT wins, pc not updated). Otherwise pc=redirect_pc.
- redirect_pc low bits are used unmodified; alignment faults are not detected in this block.
- Response arriving in S_REQ/S_HOLD/S_HALT is a protocol error: ignored, no state change.
- Reset mid-transaction: all state returns to reset values immediately. An outstanding memory response after reset is ignored (state is S_REQ).

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response, inst_ready=1, mem returns 0x00000413 at 0x80000000 and 0x00100513 at 0x80000004 -> imem_addr 0x80000000 then 0x80000004. inst_pc matches each instruction. One instruction per 3 cycles. fetch_cnt=2.
- Decoder backpressure: inst_ready=0 for 5 cycles in S_HOLD -> inst/inst_pc stable, inst_valid=1, no new imem_req_valid. After inst_ready=1, next addr is inst_pc+4.
- Redirect to 0x80000100 while in S_WAIT, response 0xdeadbeef arrives later -> response dropped, inst_valid stays 0, next imem_addr=0x80000100, fetch_cnt unchanged.
- Redirect to 0x80000200 in S_HOLD with inst_ready=1 -> fetch_cnt+1, next imem_addr=0x80000200. Same with inst_ready=0 -> inst_valid drops, fetch_cnt unchanged.
- Deliver 0x00100073 at 0x80000008 -> after handshake halted=1, imem_req_valid=0 forever. A redirect afterwards has no effect. fetch_cnt=3.
- Assert rst_n=0 in S_WAIT, release, then a stale response arrives -> ignored. First request is to 0x80000000, fetch_cnt=0, halted=0.
